mem_access_unit: RTL

MEM-stage load/store unit that consumes the memory control signals issued by the pipeline controller (memtoregM, memwriteM, memsignextM, membyteM) and acts as the CPU-side initiator on the SRAM-like data bus. It generates size, byte strobes and replicated write data, and detects misaligned addresses. It stalls the pipeline while a transaction is outstanding, then returns aligned, sign- or zero-extended load data toward WB. It sits between the MEM pipeline register and the data bus and drives the hazard unit's MEM stall input.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving an SRAM-like data bus
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic        memsignextM,
  input  logic [1:0]  membyteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  input  logic        holdM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] readdataM,
  output logic        stallmemM,
  output logic        adelM,
  output logic        adesM
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] r_rdata;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_mem_op;
  logic        w_acc;
  logic [1:0]  w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_req;
  logic        w_stall;
  logic [31:0] w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode access size and alignment; membyteM=11 behaves as a word access
  always_comb begin
    w_is_byte    = (membyteM == 2'b10);
    w_is_half    = (membyteM == 2'b01);
    w_is_word    = ~w_is_byte & ~w_is_half;
    w_misaligned = (w_is_half & aluoutM[0]) | (w_is_word & (aluoutM[1:0] != 2'b00));
    w_mem_op     = memtoregM | memwriteM;
    w_acc        = w_mem_op & ~w_misaligned & ~flushM;
  end

  assign adelM = memtoregM & w_misaligned;
  assign adesM = memwriteM & w_misaligned;

  // Store encoding: size, byte strobes and lane-replicated write data
  always_comb begin
    w_size  = 2'd2;
    w_wstrb = 4'b1111;
    w_wdata = writedataM;
    if (w_is_byte) begin
      w_size  = 2'd0;
      w_wstrb = 4'b0001 << aluoutM[1:0];
      w_wdata = {4{writedataM[7:0]}};
    end else if (w_is_half) begin
      w_size  = 2'd1;
      w_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{writedataM[15:0]}};
    end
    if (!memwriteM) begin
      w_wstrb = 4'b0000;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a held instruction in DONE never re-enters IDLE until the pipeline moves
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && data_addr_ok) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok && flushM) w_next = S_IDLE;
        else if (data_data_ok)      w_next = S_DONE;
        else if (flushM)            w_next = S_DISCARD;
      end
      S_DONE: begin
        if (!holdM || flushM) w_next = S_IDLE;
      end
      S_DISCARD: begin
        if (data_data_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state request and stall; DISCARD stalls a new access until the orphan response drains
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req   = w_acc;
        w_stall = w_acc;
      end
      S_WAIT: begin
        w_stall = 1'b1;
      end
      S_DONE: begin
        w_stall = 1'b0;
      end
      S_DISCARD: begin
        w_stall = w_mem_op & ~w_misaligned;
      end
      default: begin
        w_req   = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  // Bus outputs are forced low while reset is asserted
  always_comb begin
    data_req   = rst & w_req;
    data_wr    = rst & memwriteM;
    data_size  = rst ? w_size : 2'd0;
    data_wstrb = rst ? w_wstrb : 4'd0;
    data_addr  = rst ? aluoutM : 32'd0;
    data_wdata = rst ? w_wdata : 32'd0;
    stallmemM  = rst & w_stall;
  end

  // Load alignment and extension using the offset/size latched at acceptance
  always_comb begin
    case (r_off)
      2'd0:    w_byte = data_rdata[7:0];
      2'd1:    w_byte = data_rdata[15:8];
      2'd2:    w_byte = data_rdata[23:16];
      default: w_byte = data_rdata[31:24];
    endcase
    w_half = r_off[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_size)
      2'd0:    w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = data_rdata;
    endcase
  end

  // Latch request attributes on acceptance and the load result on a non-flushed response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_off   <= 2'd0;
      r_size  <= 2'd0;
      r_sext  <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == S_IDLE && w_acc && data_addr_ok) begin
        r_off  <= aluoutM[1:0];
        r_size <= w_size;
        r_sext <= memsignextM;
      end
      if (r_state == S_WAIT && data_data_ok && !flushM) begin
        r_rdata <= w_load;
      end
    end
  end

  assign readdataM = r_rdata;

endmodule
